// File: rtl/hack_pkg.sv
// Shared Hack ISA definitions: widths, instruction field positions, comp
// encodings and a decode helper used by the CPU core and its benches.
package hack_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 15;

  // Instruction bit positions
  localparam int TYPE_BIT = 15;
  localparam int A_BIT    = 12;
  localparam int COMP_MSB = 11;
  localparam int COMP_LSB = 6;
  localparam int DEST_A   = 5;
  localparam int DEST_D   = 4;
  localparam int DEST_M   = 3;
  localparam int JLT      = 2;
  localparam int JEQ      = 1;
  localparam int JGT      = 0;

  // Named comp encodings (zx,nx,zy,ny,f,no); "A" reads as "M" when a=1
  localparam logic [5:0] COMP_ZERO        = 6'b101010;
  localparam logic [5:0] COMP_ONE         = 6'b111111;
  localparam logic [5:0] COMP_MINUS_ONE   = 6'b111010;
  localparam logic [5:0] COMP_D           = 6'b001100;
  localparam logic [5:0] COMP_A           = 6'b110000;
  localparam logic [5:0] COMP_NOT_D       = 6'b001101;
  localparam logic [5:0] COMP_NOT_A       = 6'b110001;
  localparam logic [5:0] COMP_NEG_D       = 6'b001111;
  localparam logic [5:0] COMP_NEG_A       = 6'b110011;
  localparam logic [5:0] COMP_D_PLUS_1    = 6'b011111;
  localparam logic [5:0] COMP_A_PLUS_1    = 6'b110111;
  localparam logic [5:0] COMP_D_MINUS_1   = 6'b001110;
  localparam logic [5:0] COMP_A_MINUS_1   = 6'b110010;
  localparam logic [5:0] COMP_D_PLUS_A    = 6'b000010;
  localparam logic [5:0] COMP_D_MINUS_A   = 6'b010011;
  localparam logic [5:0] COMP_A_MINUS_D   = 6'b000111;
  localparam logic [5:0] COMP_D_AND_A     = 6'b000000;
  localparam logic [5:0] COMP_D_OR_A      = 6'b010101;

  // Decoded view of one instruction word
  typedef struct packed {
    logic       is_c;
    logic       a;
    logic [5:0] comp;
    logic       dest_a;
    logic       dest_d;
    logic       dest_m;
    logic       jlt;
    logic       jeq;
    logic       jgt;
  } hack_decode_t;

  // Field split; destination and jump bits only mean something for C-instructions
  function automatic hack_decode_t hack_decode(input logic [DATA_W-1:0] instr);
    hack_decode_t d;
    d.is_c   = instr[TYPE_BIT];
    d.a      = instr[A_BIT];
    d.comp   = instr[COMP_MSB:COMP_LSB];
    d.dest_a = instr[TYPE_BIT] & instr[DEST_A];
    d.dest_d = instr[TYPE_BIT] & instr[DEST_D];
    d.dest_m = instr[TYPE_BIT] & instr[DEST_M];
    d.jlt    = instr[TYPE_BIT] & instr[JLT];
    d.jeq    = instr[TYPE_BIT] & instr[JEQ];
    d.jgt    = instr[TYPE_BIT] & instr[JGT];
    return d;
  endfunction

endpackage

// File: rtl/hack_alu.sv
// Combinational Hack ALU: optional zero/negate on each operand, add or AND,
// optional output negate, plus zero and negative flags.
module hack_alu
  import hack_pkg::*;
(
  input  logic [DATA_W-1:0] x,
  input  logic [DATA_W-1:0] y,
  input  logic              zx,
  input  logic              nx,
  input  logic              zy,
  input  logic              ny,
  input  logic              f,
  input  logic              no,
  output logic [DATA_W-1:0] out,
  output logic              zr,
  output logic              ng
);

  logic [DATA_W-1:0] x_z;
  logic [DATA_W-1:0] x_n;
  logic [DATA_W-1:0] y_z;
  logic [DATA_W-1:0] y_n;
  logic [DATA_W-1:0] fn;

  // Operand preset, function select and flags; carry out of the add is dropped
  always_comb begin
    x_z = zx ? '0 : x;
    x_n = nx ? ~x_z : x_z;
    y_z = zy ? '0 : y;
    y_n = ny ? ~y_z : y_z;
    fn  = f ? (x_n + y_n) : (x_n & y_n);
    out = no ? ~fn : fn;
    zr  = (out == '0);
    ng  = out[DATA_W-1];
  end

endmodule

// File: rtl/hack_pc.sv
// Program counter: asynchronous reset to RESET_PC, otherwise load a jump
// target or increment, wrapping modulo 2^ADDR_W.
module hack_pc #(
  parameter int              ADDR_W   = 15,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] target,
  output logic [ADDR_W-1:0] pc
);

  // PC register: reset wins, then jump load, else sequential fetch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= target;
    end else begin
      pc <= pc + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/hack_cpu_core.sv
// Hack CPU core: A/D registers, instruction decode, ALU operand steering,
// memory write enable and jump decision. One instruction per clock.
module hack_cpu_core #(
  parameter int                ADDR_W   = 15,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [hack_pkg::DATA_W-1:0] instruction_i,
  input  logic [hack_pkg::DATA_W-1:0] inM_i,
  output logic [hack_pkg::DATA_W-1:0] outM_o,
  output logic                        writeM_o,
  output logic [ADDR_W-1:0]           addressM_o,
  output logic [ADDR_W-1:0]           pc_o
);

  import hack_pkg::*;

  hack_decode_t      dec;
  logic [DATA_W-1:0] a_reg;
  logic [DATA_W-1:0] d_reg;
  logic [DATA_W-1:0] alu_y;
  logic [DATA_W-1:0] alu_out;
  logic              alu_zr;
  logic              alu_ng;
  logic              take;
  logic [1:0]        unused_bits;

  // Bits 14:13 of a C-instruction carry no meaning
  assign unused_bits = instruction_i[14:13];

  // Decode, operand select, write enable and jump decision, all from current state
  always_comb begin
    dec      = hack_decode(instruction_i);
    alu_y    = dec.a ? inM_i : a_reg;
    take     = dec.is_c & ((dec.jlt & alu_ng) |
                           (dec.jeq & alu_zr) |
                           (dec.jgt & ~alu_zr & ~alu_ng));
    writeM_o = ~rst_i & dec.dest_m;
  end

  // Memory address and jump target both come from A as held before the edge
  assign addressM_o = a_reg[ADDR_W-1:0];
  assign outM_o     = alu_out;

  hack_alu u_alu (
    .x   (d_reg),
    .y   (alu_y),
    .zx  (dec.comp[5]),
    .nx  (dec.comp[4]),
    .zy  (dec.comp[3]),
    .ny  (dec.comp[2]),
    .f   (dec.comp[1]),
    .no  (dec.comp[0]),
    .out (alu_out),
    .zr  (alu_zr),
    .ng  (alu_ng)
  );

  // A register: loaded by A-instructions or by a C-instruction with dest A
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      a_reg <= '0;
    end else if (!dec.is_c) begin
      a_reg <= instruction_i;
    end else if (dec.dest_a) begin
      a_reg <= alu_out;
    end
  end

  // D register: loaded only by a C-instruction with dest D
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      d_reg <= '0;
    end else if (dec.dest_d) begin
      d_reg <= alu_out;
    end
  end

  hack_pc #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk    (clk_i),
    .rst    (rst_i),
    .load   (take),
    .target (a_reg[ADDR_W-1:0]),
    .pc     (pc_o)
  );

endmodule

// File: tb/tb_hack_cpu_core.sv
// Bench for hack_cpu_core: directed programs plus random instructions checked
// against an instruction-level model of A, D and PC.
module tb_hack_cpu_core;

  logic        clk;
  logic        rst_i;
  logic [15:0] instruction_i;
  logic [15:0] inM_i;
  logic [15:0] outM_o;
  logic        writeM_o;
  logic [14:0] addressM_o;
  logic [14:0] pc_o;

  int compared   = 0;
  int mismatched = 0;

  // Clock: 10 time-unit period, rising edges at 5, 15, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  hack_cpu_core dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .instruction_i (instruction_i),
    .inM_i         (inM_i),
    .outM_o        (outM_o),
    .writeM_o      (writeM_o),
    .addressM_o    (addressM_o),
    .pc_o          (pc_o)
  );

  // Reference machine state
  logic [15:0] m_a;
  logic [15:0] m_d;
  logic [14:0] m_pc;
  logic [15:0] pend_instr;
  logic [15:0] pend_r;
  logic        pend_take;

  // The 18 defined Hack computations
  logic [5:0] comps [18] = '{6'b101010, 6'b111111, 6'b111010, 6'b001100,
                             6'b110000, 6'b001101, 6'b110001, 6'b001111,
                             6'b110011, 6'b011111, 6'b110111, 6'b001110,
                             6'b110010, 6'b000010, 6'b010011, 6'b000111,
                             6'b000000, 6'b010101};

  // Meaning of each comp code as plain arithmetic on x=D and y=A/M
  function automatic logic [15:0] comp_ref(input logic [5:0] c,
                                           input logic [15:0] x,
                                           input logic [15:0] y);
    case (c)
      6'b101010: return 16'd0;
      6'b111111: return 16'd1;
      6'b111010: return 16'hFFFF;
      6'b001100: return x;
      6'b110000: return y;
      6'b001101: return ~x;
      6'b110001: return ~y;
      6'b001111: return 16'd0 - x;
      6'b110011: return 16'd0 - y;
      6'b011111: return x + 16'd1;
      6'b110111: return y + 16'd1;
      6'b001110: return x - 16'd1;
      6'b110010: return y - 16'd1;
      6'b000010: return x + y;
      6'b010011: return x - y;
      6'b000111: return y - x;
      6'b000000: return x & y;
      6'b010101: return x | y;
      default:   return 16'hxxxx;
    endcase
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one instruction at the falling edge and check combinational outputs
  task automatic present(input logic [15:0] instr, input logic [15:0] inm);
    logic [15:0] y;
    logic [15:0] r;
    logic        is_c;
    @(negedge clk);
    instruction_i = instr;
    inM_i         = inm;
    #1;
    is_c = instr[15];
    y    = instr[12] ? inm : m_a;
    r    = comp_ref(instr[11:6], m_d, y);
    pend_instr = instr;
    pend_r     = r;
    pend_take  = is_c && ((instr[2] && $signed(r) < 0) ||
                          (instr[1] && r == 16'd0) ||
                          (instr[0] && $signed(r) > 0));
    check("pc", {1'b0, pc_o}, {1'b0, m_pc});
    check("addressM", {1'b0, addressM_o}, {1'b0, m_a[14:0]});
    check("writeM", {15'd0, writeM_o}, {15'd0, is_c & instr[3]});
    if (is_c) check("outM", outM_o, r);
  endtask

  // Let the rising edge execute the presented instruction; advance the model
  task automatic commit();
    logic [15:0] old_a;
    @(posedge clk);
    old_a = m_a;
    if (!pend_instr[15]) begin
      m_a = pend_instr;
    end else begin
      if (pend_instr[4]) m_d = pend_r;
      if (pend_instr[5]) m_a = pend_r;
    end
    m_pc = pend_take ? old_a[14:0] : m_pc + 15'd1;
  endtask

  task automatic step(input logic [15:0] instr, input logic [15:0] inm);
    present(instr, inm);
    commit();
  endtask

  // Raise reset between edges, check the forced outputs, release after an edge
  task automatic reset_pulse();
    rst_i = 1'b1;
    #1;
    check("rst_pc", {1'b0, pc_o}, 16'h0000);
    check("rst_writeM", {15'd0, writeM_o}, 16'h0000);
    check("rst_addressM", {1'b0, addressM_o}, 16'h0000);
    @(posedge clk);
    #1;
    check("rst_hold_pc", {1'b0, pc_o}, 16'h0000);
    rst_i = 1'b0;
    m_a  = 16'd0;
    m_d  = 16'd0;
    m_pc = 15'd0;
  endtask

  initial begin
    logic [15:0] instr;
    rst_i         = 1'b0;
    instruction_i = 16'hE308;
    inM_i         = 16'h0000;
    m_a  = 16'd0;
    m_d  = 16'd0;
    m_pc = 15'd0;
    pend_instr = 16'd0;
    pend_r     = 16'd0;
    pend_take  = 1'b0;

    reset_pulse();

    // Add-and-store: D = 0x11 + 3, then M[0] = D
    step(16'h0011, 16'h0000);
    step(16'hEC10, 16'h0000);
    step(16'h0003, 16'h0000);
    step(16'hE090, 16'h0000);
    step(16'h0000, 16'h0000);
    present(16'hE308, 16'h1234);
    check("store_writeM", {15'd0, writeM_o}, 16'h0001);
    check("store_outM", outM_o, 16'h0014);
    check("store_addressM", {1'b0, addressM_o}, 16'h0000);
    commit();

    // D;JGT taken with D=0x14, then D;JLT falls through
    step(16'h000A, 16'h0000);
    step(16'hE301, 16'h0000);
    present(16'hE304, 16'h0000);
    check("jgt_target", {1'b0, pc_o}, 16'h000A);
    commit();
    present(16'hE300, 16'h0000);
    check("jlt_fallthrough", {1'b0, pc_o}, 16'h000B);
    commit();

    // M operand: D = 0x11 - 3
    step(16'h0011, 16'h0000);
    step(16'hEC10, 16'h0000);
    present(16'hF4D0, 16'h0003);
    check("dminusm_writeM", {15'd0, writeM_o}, 16'h0000);
    commit();
    present(16'hE300, 16'h0000);
    check("dminusm_d", outM_o, 16'h000E);
    commit();

    // AM=M+1;JMP with A=5: write and jump use the old A
    step(16'h0005, 16'h0000);
    present(16'hFDEF, 16'h0007);
    check("amjmp_outM", outM_o, 16'h0008);
    check("amjmp_writeM", {15'd0, writeM_o}, 16'h0001);
    check("amjmp_addressM", {1'b0, addressM_o}, 16'h0005);
    commit();
    present(16'hE300, 16'h0000);
    check("amjmp_pc", {1'b0, pc_o}, 16'h0005);
    check("amjmp_a", {1'b0, addressM_o}, 16'h0008);
    commit();

    // PC wrap: jump to 0x7FFF, then an A-instruction there
    step(16'h7FFF, 16'h0000);
    step(16'hEA87, 16'h0000);
    present(16'h0000, 16'h0000);
    check("wrap_at_top", {1'b0, pc_o}, 16'h7FFF);
    commit();
    present(16'hE300, 16'h0000);
    check("wrap_to_zero", {1'b0, pc_o}, 16'h0000);
    commit();

    // Random instruction stream
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 1) == 0) begin
        instr = {1'b0, 15'($urandom)};
      end else begin
        instr = {1'b1, 2'($urandom), 1'($urandom),
                 comps[$urandom_range(0, 17)], 3'($urandom), 3'($urandom)};
      end
      step(instr, 16'($urandom_range(0, 65535)));
    end

    // Reset mid-run: reach PC=5, present a store, then reset between edges
    reset_pulse();
    for (int i = 0; i < 5; i++) step(16'h0100 + 16'(i), 16'h0000);
    present(16'hE308, 16'h0000);
    check("midrun_pc_before", {1'b0, pc_o}, 16'h0005);
    reset_pulse();
    present(16'hE300, 16'h0000);
    check("midrun_d_cleared", outM_o, 16'h0000);
    check("midrun_a_cleared", {1'b0, addressM_o}, 16'h0000);
    check("midrun_pc_start", {1'b0, pc_o}, 16'h0000);
    commit();

    // A few more random steps after the reset
    for (int i = 0; i < 50; i++) begin
      instr = ($urandom_range(0, 1) == 0) ? {1'b0, 15'($urandom)} :
              {3'b111, 1'($urandom), comps[$urandom_range(0, 17)],
               3'($urandom), 3'($urandom)};
      step(instr, 16'($urandom_range(0, 65535)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
